countdown_timer: RTL

//   Down-counting timer: loads a reload value on start, decrements once per prescaled tick,

---
 rtl/countdown_timer.sv | 99 +++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Prescaled down-counting timer with one-shot and auto-reload modes.
// Loads a reload value on start, decrements once per tick and pulses expire_o on underflow.
module countdown_timer #(
    parameter int unsigned WORD_WIDTH     = 16,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      periodic_i,
    input  logic [WORD_WIDTH-1:0]     reload_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic [WORD_WIDTH-1:0]     d_o,
    output logic                      busy_o,
    output logic                      expire_o,
    output logic                      will_underflow_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [WORD_WIDTH-1:0]     count_q, count_d;
    logic                      expire_q, expire_d;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic [WORD_WIDTH-1:0]     reload_q, reload_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      periodic_q, periodic_d;

    // State and shadow registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            expire_q   <= 1'b0;
            pre_q      <= '0;
            reload_q   <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            expire_q   <= expire_d;
            pre_q      <= pre_d;
            reload_q   <= reload_d;
            prescale_q <= prescale_d;
            periodic_q <= periodic_d;
        end
    end

    // Next-state: stop beats start, start beats a pending tick
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        expire_d   = 1'b0;
        pre_d      = pre_q;
        reload_d   = reload_q;
        prescale_d = prescale_q;
        periodic_d = periodic_q;

        if (stop_i) begin
            state_d = IDLE;
            pre_d   = '0;
        end else if (start_i) begin
            state_d    = RUN;
            count_d    = reload_i;
            pre_d      = '0;
            reload_d   = reload_i;
            prescale_d = prescale_i;
            periodic_d = periodic_i;
        end else if (state_q == RUN) begin
            if (pre_q == prescale_q) begin
                pre_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - WORD_WIDTH'(1);
                end else begin
                    // Zero means this tick underflows: never wrap the count
                    expire_d = 1'b1;
                    if (periodic_q) begin
                        count_d = reload_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end else begin
                pre_d = pre_q + PRESCALE_WIDTH'(1);
            end
        end
    end

    assign d_o              = count_q;
    assign busy_o           = (state_q == RUN);
    assign expire_o         = expire_q;
    assign will_underflow_o = busy_o & (count_q == '0);

endmodule
